// File: rtl/moore_no.sv
// moore_no: Moore-type non-overlapping "101" serial detector; MOORE_NO_DETECT_COUNT_EN adds a saturating det_count.
// Latency: z is high in the cycle after the edge that samples the final 1 of the pattern.
// Backpressure: none; one bit of x is consumed on every rising clk edge.
module moore_no #(
  parameter int CNT_W = 8
) (
  output logic z,
  input  logic x,
  input  logic clk,
  input  logic reset
`ifdef MOORE_NO_DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_no: CNT_W must be at least 1");
  end

  // Leaving S3 never uses the pattern's last 1, which makes detection non-overlapping.
  always_comb begin
    state_nxt = S0;
    unique case (state)
      S0: state_nxt = x ? S1 : S0;
      S1: state_nxt = x ? S1 : S2;
      S2: state_nxt = x ? S3 : S0;
      S3: state_nxt = x ? S1 : S0;
    endcase
  end

  // z is registered alongside the state so it always equals (state == S3).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= (state_nxt == S3);
    end
  end

`ifdef MOORE_NO_DETECT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_count <= '0;
    end else if (state_nxt == S3 && det_count != CNT_MAX) begin
      det_count <= det_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_moore_no.sv
// Directed, table-driven bench for the moore_no "101" detector.
module tb_moore_no;

`ifdef MOORE_NO_DETECT_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic clk;
  logic reset;
  logic x;
  logic z;
`ifdef MOORE_NO_DETECT_COUNT_EN
  logic [CNT_W-1:0] det_count;
`endif

  int checks;
  int failures;

  moore_no #(.CNT_W(CNT_W)) dut (
    .z        (z),
    .x        (x),
    .clk      (clk),
    .reset    (reset)
`ifdef MOORE_NO_DETECT_COUNT_EN
    ,
    .det_count(det_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic x;
    logic z_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives inputs just after a falling edge and samples z on the next falling edge.
  task automatic step(input logic r, input logic xv, input logic z_exp, input string name);
    reset = r;
    x     = xv;
    @(posedge clk);
    @(negedge clk);
    check(name, {31'd0, z}, {31'd0, z_exp});
  endtask

  task automatic push(input logic r, input logic xv, input logic ze);
    vec_t v;
    v.rst   = r;
    v.x     = xv;
    v.z_exp = ze;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    x        = 1'b0;
    #1;
    check("reset_z", {31'd0, z}, 32'd0);

    // Reset held: x toggles, no detection.
    push(1, 1, 0); push(1, 0, 0); push(1, 1, 0); push(1, 1, 0);
    // 101 right after reset, then return to S0.
    push(0, 1, 0); push(0, 0, 0); push(0, 1, 1); push(0, 0, 0);
    // Non-overlap: 10101 fires once.
    push(0, 1, 0); push(0, 0, 0); push(0, 1, 1); push(0, 0, 0); push(0, 1, 0);
    push(0, 0, 0); push(0, 0, 0);
    // Restart after detection: 101101 fires twice.
    push(0, 1, 0); push(0, 0, 0); push(0, 1, 1); push(0, 1, 0); push(0, 0, 0);
    push(0, 1, 1); push(0, 0, 0);
    // 11001 never fires.
    push(0, 1, 0); push(0, 1, 0); push(0, 0, 0); push(0, 0, 0); push(0, 1, 0);
    push(0, 0, 0); push(0, 0, 0);
    // 1101 fires via the S1 self-loop.
    push(0, 1, 0); push(0, 1, 0); push(0, 0, 0); push(0, 1, 1); push(0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].x, vecs[i].z_exp, $sformatf("vec%0d", i));
    end

    // Async reset while z is high clears it without a clock edge.
    step(0, 1, 0, "ar_a1");
    step(0, 0, 0, "ar_a0");
    step(0, 1, 1, "ar_a2");
    #1 reset = 1'b1;
    #1 check("async_clear_z", {31'd0, z}, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset in S2: a single 1 afterwards must not detect.
    step(0, 1, 0, "mid_1");
    step(0, 0, 0, "mid_0");
    #2 reset = 1'b1;
    #1 check("mid_reset_z", {31'd0, z}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    step(0, 1, 0, "mid_after_1");
    step(0, 0, 0, "mid_after_0");
    step(0, 1, 1, "mid_after_full");
    step(0, 0, 0, "mid_tail");

`ifdef MOORE_NO_DETECT_COUNT_EN
    begin
      int exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
      reset = 1'b1;
      #1 check("cnt_reset", {30'd0, det_count}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 6; d++) begin
        step(0, 1, 0, "cnt_p1");
        step(0, 0, 0, "cnt_p0");
        step(0, 1, 1, "cnt_p2");
        check($sformatf("cnt_det%0d", d), {30'd0, det_count}, exp_cnt[d]);
        step(0, 0, 0, "cnt_gap");
      end
      #1 reset = 1'b1;
      #1 check("cnt_async_clear", {30'd0, det_count}, 32'd0);
      reset = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
